// File: rtl/scarv_cop_issue_pkg.sv
// Shared coprocessor-issue definitions: ISE opcode values, request/response
// layouts and the opcode test used on the request FIFO head.
package scarv_cop_issue_pkg;

    localparam logic [6:0] ISE_OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] ISE_OPC_CUSTOM1 = 7'b0101011;
    localparam logic [6:0] ISE_OPC_CUSTOM2 = 7'b1011011;

    localparam int unsigned INSN_W     = 32;
    localparam int unsigned RSP_RD_W   = 5;
    localparam int unsigned RSP_DATA_W = 32;

    typedef struct packed {
        logic [INSN_W-1:0]     enc;
        logic [RSP_DATA_W-1:0] rs1;
        logic [RSP_DATA_W-1:0] rs2;
    } req_t;

    typedef struct packed {
        logic                  abrt;
        logic                  wen;
        logic [RSP_RD_W-1:0]   rd;
        logic [RSP_DATA_W-1:0] wdata;
    } rsp_t;

    function automatic logic is_ise_opcode(input logic [6:0] opc);
        return (opc == ISE_OPC_CUSTOM0) || (opc == ISE_OPC_CUSTOM1) ||
               (opc == ISE_OPC_CUSTOM2);
    endfunction

endpackage

// File: rtl/scarv_cop_issue_fifo.sv
// Parameterised synchronous FIFO with full/empty flags; DEPTH must be a
// power of two so the pointers wrap naturally.
module scarv_cop_issue_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is cleared too so the head reads as zero straight after reset.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/scarv_cop_issue.sv
// Host-side ISE coprocessor issue/response bridge.
// Optional watchdog: define SCARV_COP_ISSUE_TIMEOUT_EN.
module scarv_cop_issue
    import scarv_cop_issue_pkg::*;
#(
    parameter int unsigned REQ_DEPTH       = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,
    input  logic [31:0] cpu_rs2,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ack,
    output logic        cpu_rsp_wen,
    output logic [4:0]  cpu_rsp_rd,
    output logic [31:0] cpu_rsp_wdata,
    output logic        cpu_rsp_abrt,
    output logic        cop_insn_valid,
    input  logic        cop_insn_ready,
    output logic [31:0] cop_insn_enc,
    output logic [31:0] cop_rs1,
    output logic [31:0] cop_rs2,
    input  logic        cop_rsp_valid,
    output logic        cop_rsp_ready,
    input  logic        cop_rsp_wen,
    input  logic [4:0]  cop_rsp_rd,
    input  logic [31:0] cop_rsp_wdata,
    input  logic        cop_rsp_abrt,
    output logic        cop_timeout,
    output logic        busy
);

    localparam logic [2:0]  OUT_LIMIT = 3'(MAX_OUTSTANDING);
    localparam int unsigned FIFO_W    = $bits(req_t);

    if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 ||
        MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("scarv_cop_issue: illegal parameter combination");
    end

    req_t       push_data;
    req_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       head_ise;
    logic       head_nonise;
    logic [2:0] outstanding;
    logic       out_zero;
    logic       dispatch;
    logic       local_reject;
    logic       rsp_accept;
    logic       rsp_take;
    logic       rsp_synth;
    logic       rsp_valid_q;
    rsp_t       rsp_q;

    assign push_data = '{enc: cpu_insn_enc, rs1: cpu_rs1, rs2: cpu_rs2};

    scarv_cop_issue_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (FIFO_W)
    ) u_req_fifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (cpu_insn_req && cpu_insn_ack),
        .pop     (fifo_pop),
        .wdata   (push_data),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cpu_insn_ack = !fifo_full;
    assign out_zero     = (outstanding == '0);
    assign head_ise     = !fifo_empty && is_ise_opcode(head.enc[6:0]);
    assign head_nonise  = !fifo_empty && !is_ise_opcode(head.enc[6:0]);

    assign cop_insn_valid = head_ise && (outstanding < OUT_LIMIT);
    assign cop_insn_enc   = head.enc;
    assign cop_rs1        = head.rs1;
    assign cop_rs2        = head.rs2;
    assign dispatch       = cop_insn_valid && cop_insn_ready;

    // Rejecting only with nothing in flight keeps the abort in program order.
    assign local_reject = head_nonise && out_zero && !rsp_valid_q;
    assign fifo_pop     = dispatch || local_reject;
    assign rsp_accept   = cop_rsp_valid && cop_rsp_ready;

`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr;
    logic             to_pend;
    logic             to_pulse;
    logic [2:0]       drop;
    logic             tmr_hit;

    // Responses stay blocked while a synthesised abort waits for the register.
    assign cop_rsp_ready = !rsp_valid_q && !to_pend;
    assign rsp_take      = rsp_accept && !out_zero && (drop == '0);
    assign rsp_synth     = to_pend && !rsp_valid_q;
    assign tmr_hit       = !out_zero && !to_pend &&
                           (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
    assign cop_timeout   = to_pulse;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            tmr      <= '0;
            to_pend  <= 1'b0;
            to_pulse <= 1'b0;
            drop     <= '0;
        end else begin
            to_pulse <= tmr_hit;
            if (tmr_hit) begin
                to_pend <= 1'b1;
            end else if (rsp_synth) begin
                to_pend <= 1'b0;
            end
            if (rsp_accept || (dispatch && out_zero) || tmr_hit) begin
                tmr <= '0;
            end else if (!out_zero && !to_pend) begin
                tmr <= tmr + 1'b1;
            end
            if (rsp_synth) begin
                drop <= drop + 3'd1;
            end else if (rsp_accept && (drop != '0)) begin
                drop <= drop - 3'd1;
            end
        end
    end
`else
    assign cop_rsp_ready = !rsp_valid_q;
    assign rsp_take      = rsp_accept && !out_zero;
    assign rsp_synth     = 1'b0;
    assign cop_timeout   = 1'b0;
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            outstanding <= '0;
        end else if (dispatch && !(rsp_take || rsp_synth)) begin
            outstanding <= outstanding + 3'd1;
        end else if (!dispatch && (rsp_take || rsp_synth)) begin
            outstanding <= outstanding - 3'd1;
        end
    end

    // The register only loads while empty, so an ack cycle never refills it.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (rsp_valid_q) begin
            if (cpu_rsp_ack) begin
                rsp_valid_q <= 1'b0;
            end
        end else if (rsp_take) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{abrt:  cop_rsp_abrt,
                             wen:   cop_rsp_wen && (cop_rsp_rd != '0),
                             rd:    cop_rsp_rd,
                             wdata: cop_rsp_wdata};
        end else if (rsp_synth) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{abrt: 1'b1, wen: 1'b0, rd: '0, wdata: '0};
        end else if (local_reject) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{abrt: 1'b1, wen: 1'b0, rd: head.enc[11:7], wdata: '0};
        end
    end

    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_wen   = rsp_q.wen;
    assign cpu_rsp_rd    = rsp_q.rd;
    assign cpu_rsp_wdata = rsp_q.wdata;
    assign cpu_rsp_abrt  = rsp_q.abrt;

    assign busy = !fifo_empty || !out_zero || rsp_valid_q;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Self-checking bench for scarv_cop_issue: directed scenarios followed by a
// randomized phase, all checked against a program-order transaction model.
module tb_scarv_cop_issue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXO  = 2;
    localparam int          NSEQ  = 8192;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        cpu_insn_req;
    logic        cpu_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic [31:0] cpu_rs2;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ack;
    logic        cpu_rsp_wen;
    logic [4:0]  cpu_rsp_rd;
    logic [31:0] cpu_rsp_wdata;
    logic        cpu_rsp_abrt;
    logic        cop_insn_valid;
    logic        cop_insn_ready;
    logic [31:0] cop_insn_enc;
    logic [31:0] cop_rs1;
    logic [31:0] cop_rs2;
    logic        cop_rsp_valid;
    logic        cop_rsp_ready;
    logic        cop_rsp_wen;
    logic [4:0]  cop_rsp_rd;
    logic [31:0] cop_rsp_wdata;
    logic        cop_rsp_abrt;
    logic        cop_timeout;
    logic        busy;

    scarv_cop_issue #(
        .REQ_DEPTH       (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .g_clk          (g_clk),
        .g_reset        (g_reset),
        .cpu_insn_req   (cpu_insn_req),
        .cpu_insn_ack   (cpu_insn_ack),
        .cpu_insn_enc   (cpu_insn_enc),
        .cpu_rs1        (cpu_rs1),
        .cpu_rs2        (cpu_rs2),
        .cpu_rsp_valid  (cpu_rsp_valid),
        .cpu_rsp_ack    (cpu_rsp_ack),
        .cpu_rsp_wen    (cpu_rsp_wen),
        .cpu_rsp_rd     (cpu_rsp_rd),
        .cpu_rsp_wdata  (cpu_rsp_wdata),
        .cpu_rsp_abrt   (cpu_rsp_abrt),
        .cop_insn_valid (cop_insn_valid),
        .cop_insn_ready (cop_insn_ready),
        .cop_insn_enc   (cop_insn_enc),
        .cop_rs1        (cop_rs1),
        .cop_rs2        (cop_rs2),
        .cop_rsp_valid  (cop_rsp_valid),
        .cop_rsp_ready  (cop_rsp_ready),
        .cop_rsp_wen    (cop_rsp_wen),
        .cop_rsp_rd     (cop_rsp_rd),
        .cop_rsp_wdata  (cop_rsp_wdata),
        .cop_rsp_abrt   (cop_rsp_abrt),
        .cop_timeout    (cop_timeout),
        .busy           (busy)
    );

    always #5 g_clk = ~g_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: instructions by sequence number, kept in three ordered lists.
    int          fifo_q[$];   // accepted, not yet dispatched/rejected
    int          prog_q[$];   // accepted, host response not yet acked
    int          cop_q[$];    // dispatched, cop response not yet accepted
    bit          rv_m;        // host response register occupied
    logic [31:0] i_enc   [NSEQ];
    logic [31:0] i_rs1   [NSEQ];
    logic [31:0] i_rs2   [NSEQ];
    logic        r_wen   [NSEQ];
    logic [4:0]  r_rd    [NSEQ];
    logic [31:0] r_wdata [NSEQ];
    logic        r_abrt  [NSEQ];
    int          seq_n = 0;
    bit          ovr_en = 1'b0;
    logic        ovr_wen;
    logic [4:0]  ovr_rd;
    logic [31:0] ovr_wdata;
    bit          last_hacc;

    function automatic bit ise(input logic [31:0] e);
        return (e[6:0] == 7'h0B) || (e[6:0] == 7'h2B) || (e[6:0] == 7'h5B);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    // rmode: 0 no cop response, 1 answer oldest dispatched, 2 stray response.
    task automatic step(input bit req, input logic [31:0] enc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input bit rdy, input int rmode, input bit ack);
        int  s;
        bit  e_ack, e_valid, hacc, disp, ctake, hack, lrej;
        logic [31:0] tmp;
        @(negedge g_clk);
        e_ack   = fifo_q.size() < DEPTH;
        e_valid = (fifo_q.size() > 0) && ise(i_enc[fifo_q[0]]) && (cop_q.size() < MAXO);
        chk1("insn_ack", cpu_insn_ack, e_ack);
        chk1("insn_valid", cop_insn_valid, e_valid);
        chk1("rsp_valid", cpu_rsp_valid, rv_m);
        chk1("rsp_ready", cop_rsp_ready, !rv_m);
        chk1("busy", busy, prog_q.size() != 0);
        chk1("timeout", cop_timeout, 1'b0);
        if (e_valid) begin
            s = fifo_q[0];
            chk32("insn_enc", cop_insn_enc, i_enc[s]);
            chk32("insn_rs1", cop_rs1, i_rs1[s]);
            chk32("insn_rs2", cop_rs2, i_rs2[s]);
        end
        if (rv_m) begin
            s = prog_q[0];
            chk1("rsp_wen", cpu_rsp_wen, r_wen[s] && (r_rd[s] != 5'd0));
            chk32("rsp_rd", {27'd0, cpu_rsp_rd}, {27'd0, r_rd[s]});
            chk32("rsp_wdata", cpu_rsp_wdata, r_wdata[s]);
            chk1("rsp_abrt", cpu_rsp_abrt, r_abrt[s]);
        end
        cpu_insn_req   = req;
        cpu_insn_enc   = enc;
        cpu_rs1        = rs1;
        cpu_rs2        = rs2;
        cop_insn_ready = rdy;
        cpu_rsp_ack    = ack;
        cop_rsp_valid  = 1'b0;
        cop_rsp_wen    = 1'b0;
        cop_rsp_rd     = 5'd0;
        cop_rsp_wdata  = 32'd0;
        cop_rsp_abrt   = 1'b0;
        if (rmode == 1 && cop_q.size() > 0) begin
            s = cop_q[0];
            cop_rsp_valid = 1'b1;
            cop_rsp_wen   = r_wen[s];
            cop_rsp_rd    = r_rd[s];
            cop_rsp_wdata = r_wdata[s];
            cop_rsp_abrt  = r_abrt[s];
        end else if (rmode == 2) begin
            tmp = $urandom;
            cop_rsp_valid = 1'b1;
            cop_rsp_wen   = 1'b1;
            cop_rsp_rd    = tmp[4:0] | 5'd1;
            cop_rsp_wdata = tmp;
            cop_rsp_abrt  = tmp[5];
        end
        hacc  = req && e_ack;
        disp  = e_valid && rdy;
        ctake = cop_rsp_valid && !rv_m && (cop_q.size() > 0);
        hack  = ack && rv_m;
        lrej  = (fifo_q.size() > 0) && !ise(i_enc[fifo_q[0]]) && (cop_q.size() == 0) && !rv_m;
        if (ctake) void'(cop_q.pop_front());
        if (hack) begin
            void'(prog_q.pop_front());
            rv_m = 1'b0;
        end else if (!rv_m && (ctake || lrej)) begin
            rv_m = 1'b1;
        end
        if (disp || lrej) begin
            s = fifo_q.pop_front();
            if (disp) begin
                if (ovr_en) begin
                    r_wen[s] = ovr_wen; r_rd[s] = ovr_rd; r_wdata[s] = ovr_wdata; r_abrt[s] = 1'b0;
                    ovr_en = 1'b0;
                end else begin
                    tmp = $urandom;
                    r_wen[s]   = tmp[0];
                    r_rd[s]    = (tmp[3:1] == 3'd0) ? 5'd0 : tmp[8:4];
                    r_abrt[s]  = (tmp[11:9] == 3'd0);
                    r_wdata[s] = $urandom;
                end
                cop_q.push_back(s);
            end
        end
        if (hacc) begin
            s = seq_n++;
            i_enc[s] = enc; i_rs1[s] = rs1; i_rs2[s] = rs2;
            if (!ise(enc)) begin
                r_wen[s] = 1'b0; r_rd[s] = enc[11:7]; r_wdata[s] = 32'd0; r_abrt[s] = 1'b1;
            end
            fifo_q.push_back(s);
            prog_q.push_back(s);
        end
        last_hacc = hacc;
    endtask

    task automatic idle(input bit rdy, input int rmode, input bit ack);
        step(1'b0, 32'd0, 32'd0, 32'd0, rdy, rmode, ack);
    endtask

    task automatic do_reset();
        @(negedge g_clk);
        cpu_insn_req = 1'b0; cop_insn_ready = 1'b0; cpu_rsp_ack = 1'b0; cop_rsp_valid = 1'b0;
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        fifo_q.delete(); prog_q.delete(); cop_q.delete(); rv_m = 1'b0; ovr_en = 1'b0;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_insn_ack", cpu_insn_ack, 1'b1);
        chk1("rst_insn_valid", cop_insn_valid, 1'b0);
        chk1("rst_rsp_valid", cpu_rsp_valid, 1'b0);
        chk1("rst_rsp_ready", cop_rsp_ready, 1'b1);
        chk32("rst_rsp_wdata", cpu_rsp_wdata, 32'd0);
        chk32("rst_insn_enc", cop_insn_enc, 32'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && prog_q.size() != 0; i++) idle(1'b1, 1, 1'b1);
        idle(1'b0, 0, 1'b0);
        chk1(tag, busy, 1'b0);
    endtask

    logic [31:0] encs [4];
    int          sent;

    initial begin
        encs[0] = 32'h0000_018B; encs[1] = 32'h0000_22AB;
        encs[2] = 32'h0000_315B; encs[3] = 32'h0000_0F8B;
        g_reset = 1'b1;
        cpu_insn_req = 1'b0; cpu_insn_enc = '0; cpu_rs1 = '0; cpu_rs2 = '0;
        cop_insn_ready = 1'b0; cpu_rsp_ack = 1'b0;
        cop_rsp_valid = 1'b0; cop_rsp_wen = 1'b0; cop_rsp_rd = '0; cop_rsp_wdata = '0; cop_rsp_abrt = 1'b0;
        do_reset();

        // Basic ISE round trip with fixed response fields.
        ovr_en = 1'b1; ovr_wen = 1'b1; ovr_rd = 5'd3; ovr_wdata = 32'hA5;
        step(1'b1, 32'h0000_100B, 32'd5, 32'd7, 1'b1, 0, 1'b0);
        idle(1'b1, 0, 1'b0);
        chk1("t1_valid_n1", cop_insn_valid, 1'b1);
        chk32("t1_enc", cop_insn_enc, 32'h0000_100B);
        idle(1'b0, 1, 1'b0);
        chk1("t1_rsp_not_yet", cpu_rsp_valid, 1'b0);
        idle(1'b0, 0, 1'b1);
        chk32("t1_wdata", cpu_rsp_wdata, 32'hA5);
        chk32("t1_rd", {27'd0, cpu_rsp_rd}, 32'd3);
        idle(1'b0, 0, 1'b0);

        // Non-ISE behind an outstanding ISE instruction.
        step(1'b1, 32'h0000_110B, 32'd1, 32'd2, 1'b1, 0, 1'b0);
        step(1'b1, 32'h0000_0033, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        repeat (4) idle(1'b0, 0, 1'b0);
        chk1("t2_no_early_abort", cpu_rsp_valid, 1'b0);
        idle(1'b0, 1, 1'b0);
        idle(1'b0, 0, 1'b1);
        idle(1'b0, 0, 1'b0);
        idle(1'b0, 0, 1'b0);
        chk1("t2_abort", cpu_rsp_abrt, 1'b1);
        chk32("t2_abort_rd", {27'd0, cpu_rsp_rd}, 32'd0);
        drain("t2_drain");

        // Coprocessor stalled, three back-to-back requests.
        sent = 0;
        for (int i = 0; i < 10; i++) begin
            step(sent < 3, encs[sent % 4], 32'(i), 32'(i * 3), 1'b0, 0, 1'b0);
            if (last_hacc) sent++;
        end
        chk32("t3_accepted", 32'(sent), 32'd2);
        chk1("t3_ack_low", cpu_insn_ack, 1'b0);
        for (int i = 0; i < 100 && sent < 3; i++) begin
            step(1'b1, encs[2], 32'h33, 32'h44, 1'b1, 1, 1'b1);
            if (last_hacc) sent++;
        end
        chk32("t3_third_sent", 32'(sent), 32'd3);
        drain("t3_drain");

        // Outstanding limit with responses withheld.
        sent = 0;
        for (int i = 0; i < 8; i++) begin
            step(sent < 3, encs[sent % 4], 32'(sent), 32'd9, 1'b1, 0, 1'b0);
            if (last_hacc) sent++;
        end
        chk1("t4_third_blocked", cop_insn_valid, 1'b0);
        idle(1'b1, 1, 1'b0);
        idle(1'b0, 0, 1'b0);
        chk1("t4_third_released", cop_insn_valid, 1'b1);
        drain("t4_drain");

        // Reset with FIFO full and two in flight.
        sent = 0;
        for (int i = 0; i < 8; i++) begin
            step(sent < 4, encs[sent % 4], 32'd1, 32'd1, 1'b1, 0, 1'b0);
            if (last_hacc) sent++;
        end
        chk1("t5_full", cpu_insn_ack, 1'b0);
        do_reset();

        // Stray cop response with nothing outstanding.
        idle(1'b0, 2, 1'b0);
        idle(1'b0, 0, 1'b0);
        chk1("stray_discarded", cpu_rsp_valid, 1'b0);
        step(1'b1, encs[3], 32'd11, 32'd12, 1'b1, 0, 1'b0);
        drain("stray_drain");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [6:0]  opc;
            r = $urandom;
            case ($urandom_range(0, 4))
                0: opc = 7'h0B;
                1: opc = 7'h2B;
                2: opc = 7'h5B;
                3: opc = 7'h33;
                default: opc = 7'h13;
            endcase
            step($urandom_range(0, 1) == 1, {r[31:7], opc}, $urandom, $urandom,
                 $urandom_range(0, 9) < 7, ($urandom_range(0, 9) < 6) ? 1 : 0,
                 $urandom_range(0, 9) < 6);
        end
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
